// File: rtl/i2c_slave_pkg.sv
// Shared types and default widths for the I2C register-file target.
package i2c_slave_pkg;

  localparam int I2C_ADDR_WIDTH = 7;
  localparam int I2C_DATA_WIDTH = 8;
  localparam logic [I2C_ADDR_WIDTH-1:0] DEFAULT_SLAVE_ADDR = 7'h22;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_PTR,
    WR_ACK,
    WR_DATA,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_slv_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings scl/sda into the clk_i domain and derives START, STOP and scl edge pulses.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s_o,
  output logic start_o,
  output logic stop_o,
  output logic scl_rise_o,
  output logic scl_fall_o
);

  // Bit 0 and 1 form the synchroniser, bit 2 holds the previous synchronised value.
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       scl_high;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_s_o    = sda_q[1];
  assign scl_high   = scl_q[1] & scl_q[2];
  assign start_o    = scl_high & sda_q[2] & ~sda_q[1];
  assign stop_o     = scl_high & ~sda_q[2] & sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a small register file and an auto-incrementing pointer;
// committed writes are reported on the wr_* port.
module i2c_slave_regfile #(
  parameter int I2C_ADDR_WIDTH = i2c_slave_pkg::I2C_ADDR_WIDTH,
  parameter int I2C_DATA_WIDTH = i2c_slave_pkg::I2C_DATA_WIDTH,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR = i2c_slave_pkg::DEFAULT_SLAVE_ADDR,
  parameter int NUM_REGS = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_o,
  output logic                        wr_strb_o,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr_o,
  output logic [I2C_DATA_WIDTH-1:0]   wr_data_o,
  output logic                        busy_o
);
  import i2c_slave_pkg::*;

  localparam int DW = I2C_DATA_WIDTH;
  localparam int PW = $clog2(NUM_REGS);
  localparam int CW = $clog2(DW + 1);

  logic sda_s, start_p, stop_p, scl_rise, scl_fall;

  i2c_bus_sync u_sync (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_s_o    (sda_s),
    .start_o    (start_p),
    .stop_o     (stop_p),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall)
  );

  i2c_slv_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  shift_q, shift_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           sda_q, sda_d;
  logic           busy_q, busy_d;
  logic           rw_q, rw_d;
  logic           wr_strb_q, wr_strb_d;
  logic [PW-1:0]  wr_addr_q, wr_addr_d;
  logic [DW-1:0]  wr_data_q, wr_data_d;
  logic [DW-1:0]  regs_q [NUM_REGS];

  logic [DW-1:0]  byte_in;
  logic [PW-1:0]  ptr_inc;

  assign byte_in = {shift_q[DW-2:0], sda_s};
  assign ptr_inc = ptr_q + PW'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_q     <= 1'b1;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      wr_strb_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_q     <= sda_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      wr_strb_q <= wr_strb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_strb_d) begin
      regs_q[ptr_q] <= byte_in;
    end
  end

  // Bus conditions override everything, so a START racing a bit sample drops the partial byte.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_d     = sda_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    wr_strb_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (start_p) begin
      state_d = ADDR;
      cnt_d   = '0;
      sda_d   = 1'b1;
    end else if (stop_p) begin
      state_d = IDLE;
      cnt_d   = '0;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_fall) begin
            sda_d = 1'b1;
          end else if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(DW - 1)) begin
              cnt_d = '0;
              if (shift_q[I2C_ADDR_WIDTH-1:0] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = sda_s;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_d = 1'b0;
          end else if (scl_rise) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d = RD_DATA;
              shift_d = regs_q[ptr_q];
            end else begin
              state_d = WR_PTR;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_d = 1'b0;
          end else if (scl_rise) begin
            state_d = WR_DATA;
            cnt_d   = '0;
          end
        end
        WR_PTR, WR_DATA: begin
          if (scl_fall) begin
            sda_d = 1'b1;
          end else if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(DW - 1)) begin
              cnt_d   = '0;
              state_d = WR_ACK;
              if (state_q == WR_PTR) begin
                ptr_d = byte_in[PW-1:0];
              end else begin
                wr_strb_d = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                ptr_d     = ptr_inc;
              end
            end
          end
        end
        // The first fall here ends the ACK slot and already carries the MSB.
        RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == CW'(DW)) begin
              sda_d   = 1'b1;
              cnt_d   = '0;
              state_d = RD_ACK;
            end else begin
              sda_d   = shift_q[DW-1];
              shift_d = {shift_q[DW-2:0], 1'b0};
              cnt_d   = cnt_q + CW'(1);
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_d   = ptr_inc;
              shift_d = regs_q[ptr_inc];
              cnt_d   = '0;
              state_d = RD_DATA;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        IGNORE: sda_d = 1'b1;
        default: begin
          state_d = IDLE;
          sda_d   = 1'b1;
        end
      endcase
    end
  end

  assign sda_o     = sda_q;
  assign busy_o    = busy_q;
  assign wr_strb_o = wr_strb_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bit-banging I2C master with a transaction-level register model for i2c_slave_regfile.
module tb_i2c_slave_regfile;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sdaM = 1'b1;
  logic       sdaBus;
  logic       sda_o, wr_strb, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  assign sdaBus = sdaM & sda_o;

  always #5 clk = ~clk;

  i2c_slave_regfile dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .scl_i     (scl),
    .sda_i     (sdaBus),
    .sda_o     (sda_o),
    .wr_strb_o (wr_strb),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .busy_o    (busy)
  );

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  int         checks = 0;
  int         failures = 0;
  bit         dutMayDrive = 1'b0;
  logic [7:0] mRegs [16];
  int         mPtr = 0;
  bit         mBusy = 1'b0;
  wr_t        expQ [$];
  wr_t        wrLog [$];
  wr_t        got, want;
  logic [7:0] wrBytes [$];
  logic [7:0] rdBytes [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: the target may only pull sda in slots the master granted, and each
  // write strobe must match the next write the model predicted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!dutMayDrive) checkOutput("sda_release", 32'(sda_o), 1);
      if (wr_strb === 1'b1) begin
        got.a = wr_addr;
        got.d = wr_data;
        wrLog.push_back(got);
        checkOutput("wr_expected", 32'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          want = expQ.pop_front();
          checkOutput("wr_addr", 32'(wr_addr), 32'(want.a));
          checkOutput("wr_data", 32'(wr_data), 32'(want.d));
        end
      end
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xferBit(input logic b, input bit mayDrive, output logic s);
    if (mayDrive) dutMayDrive = 1'b1;
    waitClk(Q);
    dutMayDrive = mayDrive;
    sdaM = b;
    waitClk(Q);
    scl = 1'b1;
    waitClk(Q);
    s = sdaBus;
    waitClk(Q);
    scl = 1'b0;
  endtask

  task automatic xferByte(input logic [7:0] tx, input bit drvData, input logic ackOut,
                          input bit drvAck, output logic [7:0] rx, output logic ackIn);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      xferBit(tx[i], drvData, s);
      rx[i] = s;
    end
    xferBit(ackOut, drvAck, ackIn);
  endtask

  task automatic i2cStart;
    if (scl == 1'b0) begin
      waitClk(Q);
      dutMayDrive = 1'b0;
      sdaM = 1'b1;
      waitClk(Q);
      scl = 1'b1;
      waitClk(Q);
    end
    sdaM = 1'b0;
    waitClk(Q);
    scl = 1'b0;
  endtask

  task automatic i2cStop;
    waitClk(Q);
    dutMayDrive = 1'b0;
    sdaM = 1'b0;
    waitClk(Q);
    scl = 1'b1;
    waitClk(Q);
    sdaM = 1'b1;
    waitClk(Q + 4);
  endtask

  task automatic finishTxn;
    i2cStop();
    mBusy = 1'b0;
    checkOutput("busy_after_stop", 32'(busy), 0);
    checkOutput("sda_after_stop", 32'(sda_o), 1);
    checkOutput("wr_all_seen", expQ.size(), 0);
  endtask

  // One addressed phase: writes send wrBytes (pointer first), reads fetch nRead bytes.
  task automatic applyStimulus(input logic [6:0] addr, input bit rw, input int nRead, input bit doStop);
    bit         match;
    bit         first;
    logic [7:0] rx, expByte;
    logic       ack;
    match = (addr == 7'h22);
    i2cStart();
    xferByte({addr, rw}, 1'b0, 1'b1, match, rx, ack);
    checkOutput("addr_ack", 32'(ack), match ? 0 : 1);
    if (match) mBusy = 1'b1;
    checkOutput("busy_after_addr", 32'(busy), 32'(mBusy));
    if (!rw) begin
      first = 1'b1;
      foreach (wrBytes[i]) begin
        if (match) begin
          if (first) begin
            mPtr = int'(wrBytes[i][3:0]);
          end else begin
            mRegs[mPtr] = wrBytes[i];
            expQ.push_back('{4'(mPtr), wrBytes[i]});
            mPtr = (mPtr + 1) % 16;
          end
        end
        first = 1'b0;
        xferByte(wrBytes[i], 1'b0, 1'b1, match, rx, ack);
        checkOutput("data_ack", 32'(ack), match ? 0 : 1);
      end
    end else begin
      rdBytes.delete();
      for (int i = 0; i < nRead; i++) begin
        expByte = mRegs[mPtr];
        xferByte(8'hFF, match, (i == nRead - 1), 1'b0, rx, ack);
        if (match) begin
          checkOutput("rd_data", 32'(rx), 32'(expByte));
          rdBytes.push_back(rx);
          if (i != nRead - 1) mPtr = (mPtr + 1) % 16;
        end else begin
          checkOutput("rd_unaddressed", 32'(rx), 32'hFF);
        end
      end
    end
    if (doStop) finishTxn();
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic       s;
    logic [6:0] addr;
    logic [7:0] adrByte;
    bit         match, rw, rs;
    int         n;

    foreach (mRegs[i]) mRegs[i] = 8'h00;

    $display("[TB] reset values");
    waitClk(2);
    checkOutput("rst_sda", 32'(sda_o), 1);
    checkOutput("rst_wr_strb", 32'(wr_strb), 0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 0);
    checkOutput("rst_wr_data", 32'(wr_data), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    waitClk(Q);

    $display("[TB] write ptr 3, A5 5A");
    wrLog.delete();
    wrBytes = '{8'h03, 8'hA5, 8'h5A};
    applyStimulus(7'h22, 1'b0, 0, 1'b1);
    checkOutput("t1_wr_count", wrLog.size(), 2);
    if (wrLog.size() == 2) begin
      checkOutput("t1_wr0_addr", 32'(wrLog[0].a), 32'h3);
      checkOutput("t1_wr0_data", 32'(wrLog[0].d), 32'hA5);
      checkOutput("t1_wr1_addr", 32'(wrLog[1].a), 32'h4);
      checkOutput("t1_wr1_data", 32'(wrLog[1].d), 32'h5A);
    end

    $display("[TB] wrong address 0x23");
    wrLog.delete();
    wrBytes = '{8'hFF};
    applyStimulus(7'h23, 1'b0, 0, 1'b1);
    checkOutput("t2_wr_count", wrLog.size(), 0);

    $display("[TB] pointer wrap");
    wrLog.delete();
    wrBytes = '{8'h0F, 8'h11, 8'h22};
    applyStimulus(7'h22, 1'b0, 0, 1'b1);
    checkOutput("t3_wr_count", wrLog.size(), 2);
    if (wrLog.size() == 2) begin
      checkOutput("t3_wr0_addr", 32'(wrLog[0].a), 32'hF);
      checkOutput("t3_wr0_data", 32'(wrLog[0].d), 32'h11);
      checkOutput("t3_wr1_addr", 32'(wrLog[1].a), 32'h0);
      checkOutput("t3_wr1_data", 32'(wrLog[1].d), 32'h22);
    end

    $display("[TB] combined write-pointer / repeated start / read");
    wrBytes = '{8'h03};
    applyStimulus(7'h22, 1'b0, 0, 1'b0);
    applyStimulus(7'h22, 1'b1, 3, 1'b0);
    checkOutput("t4_rd_count", rdBytes.size(), 3);
    if (rdBytes.size() == 3) begin
      checkOutput("t4_rd0", 32'(rdBytes[0]), 32'hA5);
      checkOutput("t4_rd1", 32'(rdBytes[1]), 32'h5A);
      checkOutput("t4_rd2", 32'(rdBytes[2]), 32'h00);
    end
    waitClk(Q);
    checkOutput("t4_sda_after_nack", 32'(sda_o), 1);
    finishTxn();

    $display("[TB] STOP inside a data byte");
    wrBytes = '{8'h05};
    applyStimulus(7'h22, 1'b0, 0, 1'b0);
    wrLog.delete();
    xferBit(1'b1, 1'b0, s);
    xferBit(1'b0, 1'b0, s);
    xferBit(1'b1, 1'b0, s);
    xferBit(1'b1, 1'b0, s);
    finishTxn();
    checkOutput("t5_no_commit", wrLog.size(), 0);
    applyStimulus(7'h22, 1'b1, 1, 1'b1);

    $display("[TB] reset during address ACK");
    i2cStart();
    adrByte = {7'h22, 1'b0};
    for (int i = 7; i >= 0; i--) xferBit(adrByte[i], 1'b0, s);
    dutMayDrive = 1'b1;
    sdaM = 1'b1;
    for (int i = 0; i < 2 * Q && sda_o !== 1'b0; i++) waitClk(1);
    checkOutput("t6_ack_driven", 32'(sda_o), 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_async_sda", 32'(sda_o), 1);
    checkOutput("t6_rst_busy", 32'(busy), 0);
    waitClk(3);
    foreach (mRegs[i]) mRegs[i] = 8'h00;
    mPtr = 0;
    mBusy = 1'b0;
    expQ.delete();
    scl = 1'b1;
    sdaM = 1'b1;
    dutMayDrive = 1'b0;
    rst_n = 1'b1;
    waitClk(Q);
    applyStimulus(7'h22, 1'b1, 1, 1'b1);
    checkOutput("t6_rd_count", rdBytes.size(), 1);
    if (rdBytes.size() == 1) checkOutput("t6_rd0", 32'(rdBytes[0]), 32'h00);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 30; t++) begin
      match = ($urandom_range(0, 4) != 0);
      addr  = match ? 7'h22 : 7'($urandom_range(0, 127));
      match = (addr == 7'h22);
      rw    = 1'($urandom_range(0, 1));
      if (!rw) begin
        wrBytes.delete();
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) wrBytes.push_back(8'($urandom));
        rs = match && ($urandom_range(0, 2) == 0);
        applyStimulus(addr, 1'b0, 0, !rs);
        if (rs) applyStimulus(7'h22, 1'b1, $urandom_range(1, 4), 1'b1);
      end else begin
        applyStimulus(addr, 1'b1, match ? $urandom_range(1, 4) : 0, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
